// File: rtl/grant_dispatch_pkg.sv
// grant_dispatch_pkg: definitions shared by grant_dispatch and its FIFO.
//   gd_state_e  dispatcher FSM states
//   idx_w()     index width needed to encode an N-bit one-hot grant
//   ERR_*       bit positions inside err_o
package grant_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } gd_state_e;

  // A 1-bit vector still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ERR_MULTI = 0;  // more than one grant bit set at capture
  localparam int ERR_OVF   = 1;  // capture dropped because the FIFO was full
  localparam int ERR_TMO   = 2;  // dn_done_i never arrived in time

endpackage

// File: rtl/gd_fifo.sv
// gd_fifo: small synchronous FIFO with fall-through head.
//   i_clk, i_rst_n    clock, async active-low reset
//   i_push, i_wdata   write request and data (ignored when full, unless popping)
//   i_pop             read request (ignored when empty)
//   o_rdata           current head entry
//   o_full, o_empty   occupancy flags
//   o_level           number of stored entries (0..DEPTH)
module gd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty.
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_push, w_pop;

  assign o_level = r_wptr - r_rptr;
  assign o_full  = (o_level == LW'(DEPTH));
  assign o_empty = (o_level == '0);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // At full, a simultaneous pop frees the slot being written.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || i_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/grant_dispatch.sv
// grant_dispatch: turns one-hot arbiter grants into a queue of client indices
// and issues them one at a time to a downstream consumer.
//   Pclk_i, PResetn_i   clock, async active-low reset
//   enable_i            allows new grants to be queued
//   gnt_i               one-hot grant; a new nonzero value queues its lowest bit
//   dn_ready_i          downstream accepts the offered index
//   dn_done_i           downstream finished the accepted index
//   dn_valid_o/dn_idx_o offered index
//   busy_o, level_o     FIFO full flag / occupancy
//   issue_cnt_o         completed issues (wraps at 16 bits)
//   err_o               sticky {timeout, overflow, multi-hot}
module grant_dispatch
  import grant_dispatch_pkg::*;
#(
  parameter  int NUM_REQUESTS = 256,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int DONE_TIMEOUT = 16,
  localparam int IDX_W        = idx_w(NUM_REQUESTS),
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1,
  localparam int TMO_W        = $clog2(DONE_TIMEOUT) + 1
) (
  input  logic                    Pclk_i,
  input  logic                    PResetn_i,
  input  logic                    enable_i,
  input  logic [NUM_REQUESTS-1:0] gnt_i,
  input  logic                    dn_ready_i,
  input  logic                    dn_done_i,
  output logic                    dn_valid_o,
  output logic [IDX_W-1:0]        dn_idx_o,
  output logic                    busy_o,
  output logic [LVL_W-1:0]        level_o,
  output logic [15:0]             issue_cnt_o,
  output logic [2:0]              err_o
);

  gd_state_e               r_state;
  logic [NUM_REQUESTS-1:0] r_gnt;
  logic                    r_dn_valid;
  logic [TMO_W-1:0]        r_tmo;
  logic [15:0]             r_cnt;
  logic [2:0]              r_err;

  logic [IDX_W-1:0]        w_idx, w_head;
  logic                    w_multi, w_new, w_push, w_ovf;
  logic                    w_done_pop, w_tmo_pop, w_pop, w_remain;
  logic                    w_full, w_empty;
  logic [LVL_W-1:0]        w_level;

  // Lowest set bit wins: scan downward so the last hit is the lowest index.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_REQUESTS - 1; i >= 0; i--)
      if (gnt_i[i]) w_idx = IDX_W'(i);
  end

  // Clearing the lowest set bit leaves something only if several were set.
  assign w_multi = |(gnt_i & (gnt_i - NUM_REQUESTS'(1)));

  // Edge detect: a held grant queues once; r_gnt tracks gnt_i even when disabled.
  assign w_new = enable_i && (|gnt_i) && (gnt_i != r_gnt);

  assign w_done_pop = (r_state == WAIT_DONE) && dn_done_i;
  assign w_tmo_pop  = (r_state == WAIT_DONE) && !dn_done_i &&
                      (r_tmo == TMO_W'(DONE_TIMEOUT - 1));
  assign w_pop      = w_done_pop || w_tmo_pop;

  assign w_push = w_new && (!w_full || w_pop);
  assign w_ovf  = w_new && w_full && !w_pop;

  // Entries left after this cycle's pop, counting a same-cycle push.
  assign w_remain = (w_level > LVL_W'(1)) || w_push;

  gd_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Pclk_i),
    .i_rst_n (PResetn_i),
    .i_push  (w_push),
    .i_wdata (w_idx),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge Pclk_i or negedge PResetn_i) begin
    if (!PResetn_i) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_dn_valid <= 1'b0;
      r_tmo      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
    end else begin
      r_gnt <= gnt_i;
      if (w_new && w_multi) r_err[ERR_MULTI] <= 1'b1;
      if (w_ovf)            r_err[ERR_OVF]   <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= ISSUE;
            r_dn_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (dn_ready_i) begin
            r_state    <= WAIT_DONE;
            r_dn_valid <= 1'b0;
            r_tmo      <= '0;
          end
        end
        WAIT_DONE: begin
          if (w_pop) begin
            if (w_done_pop) r_cnt <= r_cnt + 16'd1;
            else            r_err[ERR_TMO] <= 1'b1;
            if (w_remain) begin
              r_state    <= ISSUE;
              r_dn_valid <= 1'b1;
            end else begin
              r_state    <= IDLE;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_dn_valid <= 1'b0;
        end
      endcase
    end
  end

  // Head only moves on a pop in WAIT_DONE, so it is stable for all of ISSUE.
  assign dn_valid_o  = r_dn_valid;
  assign dn_idx_o    = r_dn_valid ? w_head : '0;
  assign busy_o      = w_full;
  assign level_o     = w_level;
  assign issue_cnt_o = r_cnt;
  assign err_o       = r_err;

endmodule
